uart_tx8: RTL and testbench
===========================

Name: uart_tx8

Overview:
- 8-bit serial transmitter: accepts one parallel byte per handshake and shifts it out on a single line.
- Frame format: 1 start bit (0), 8 data bits LSB-first, 1 stop bit (1).
- It is the sending end for the lab's serial-in/parallel-out receive registers; it drives their serial input.
- Bit timing comes from an internal clock-divide counter, so it runs in the same single clock domain as the 8-bit register blocks.

Parameters:
- CLKS_PER_BIT, default 4: clk cycles per serial bit. Legal range 1..65535. The counter width is derived from it.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset. Single clock, async active-high reset; ports named clk and rst.
- d  in  8  parallel data byte; sampled only on an accepted handshake.
- valid  in  1  d holds a byte to send.
- ready  out  1  transmitter idle; a byte is accepted at a rising edge where valid && ready.
- txd  out  1  serial output; idle level is 1.
- busy  out  1  a frame is in progress (equals ~ready).

Behaviour:
- Reset: while rst=1, the following hold immediately, without waiting for a clk edge:
  - state=IDLE, txd=1, ready=1, busy=0
  - shift register=8'h00, bit counter=0, divide counter=0
- Reset mid-frame aborts the frame. No partial byte is resumed after rst falls.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - txd=1, ready=1.
  - On a rising edge with valid=1: latch d into the shift register, clear the divide counter, go to START.
  - From the next cycle: txd=0, ready=0, busy=1.
- START:
  - txd=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - txd = shift register bit 0, held for CLKS_PER_BIT cycles.
  - At the end of each bit period: shift right by 1 and increment the bit index.
  - After bit index 7 completes, go to STOP.
- STOP:
  - txd=1 for CLKS_PER_BIT cycles, then return to IDLE.
  - ready=1 from the first cycle after the stop period.
- Frame timing:
  - Frame length is exactly 10*CLKS_PER_BIT cycles, measured from the first txd=0 cycle to the first cycle ready is 1 again.
  - Minimum spacing between the accept edges of back-to-back bytes is 10*CLKS_PER_BIT+1 cycles. The spec requires no gap beyond the one IDLE cycle; valid may stay high continuously.
- Divide counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - With CLKS_PER_BIT=1, every state lasts one cycle per bit. This is legal.
- Boundary conditions:
  - valid while busy=1 is ignored. Nothing is queued, and d changes mid-frame do not affect the byte in flight.
  - valid that drops before an edge where ready=1 transfers nothing.
  - rst asserted in the same cycle as valid: reset wins and no byte is accepted.
  - txd never glitches to 0 in IDLE.

Test Plan:
- Reset check (CLKS_PER_BIT=4, 20 ns period):
  - Stimulus: rst=1 at t=0, released at 25 ns; valid=0.
  - Required: txd=1, ready=1, busy=0 throughout; no transitions on txd.
- Single byte:
  - Stimulus: d=8'b10011001 with valid pulsed one cycle.
  - Required: txd sequence per 4-cycle bit is 0 | 1,0,0,1,1,0,0,1 | 1.
  - ready low for exactly 40 cycles, then high.
- Back-to-back:
  - Stimulus: valid held high, d=8'h01 then 8'h02 presented at consecutive accepts.
  - Required: two frames with one IDLE cycle between them.
  - Data bits 1,0,0,0,0,0,0,0 then 0,1,0,0,0,0,0,0.
- Ignore while busy:
  - Stimulus: start 8'h55; at cycle 12 of the frame, pulse valid with d=8'hFF.
  - Required: the frame still carries 8'h55; no second frame starts.
- Async reset mid-frame:
  - Stimulus: start 8'h00; raise rst in the middle of bit 3, not on a clk edge.
  - Required: txd=1, ready=1 in the same time step.
  - After rst falls, a new 8'hA5 frame is sent correctly.
- CLKS_PER_BIT=1 build:
  - Stimulus: send 8'hC3.
  - Required: txd = 0,1,1,0,0,0,0,1,1,1 on consecutive cycles; 10-cycle frame.

Source files
------------

// File: rtl/uart_tx8_if.sv
// Byte handshake between a producer and the uart_tx8 serial transmitter.
// A byte moves on a rising edge where valid && ready.
interface uart_tx8_if;
  logic [7:0] d;
  logic       valid;
  logic       ready;

  modport master (output d, output valid, input ready);
  modport slave  (input d, input valid, output ready);
endinterface

// File: rtl/uart_tx8.sv
// 8N1 serial transmitter: one byte per handshake, shifted out LSB-first
// with bit timing from an internal clock-divide counter.
//
// state | meaning
// IDLE  | line high, ready for a byte
// START | start bit (0) for CLKS_PER_BIT cycles
// DATA  | eight data bits, LSB first
// STOP  | stop bit (1) for CLKS_PER_BIT cycles
module uart_tx8 #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  uart_tx8_if.slave   bus,
  output logic        txd,
  output logic        busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            txd_q, txd_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= 8'h00;
      txd_q   <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    cnt_d   = bit_end ? '0 : cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.valid) begin
          shift_d = bus.d;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          bit_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they land in flops
    // and line up with the state they describe.
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = ~ready_d;
  end

  assign bus.ready = ready_q;
  assign txd       = txd_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx8.sv
// Directed bench for uart_tx8: one instance at CLKS_PER_BIT=4, one at
// CLKS_PER_BIT=1, line sampled on the falling clock edge.
module tb_uart_tx8;

  logic clk;
  logic rst;
  logic tx4, busy4, tx1, busy1;

  uart_tx8_if if4 ();
  uart_tx8_if if1 ();

  uart_tx8 #(.CLKS_PER_BIT(4)) dut4 (
    .clk  (clk),
    .rst  (rst),
    .bus  (if4.slave),
    .txd  (tx4),
    .busy (busy4)
  );

  uart_tx8 #(.CLKS_PER_BIT(1)) dut1 (
    .clk  (clk),
    .rst  (rst),
    .bus  (if1.slave),
    .txd  (tx1),
    .busy (busy1)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  logic txl4 [0:127];
  logic rdl4 [0:127];
  logic bsl4 [0:127];
  logic txl1 [0:127];
  logic rdl1 [0:127];

  task automatic capture(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      txl4[base+i] = tx4;
      rdl4[base+i] = if4.ready;
      bsl4[base+i] = busy4;
      txl1[base+i] = tx1;
      rdl1[base+i] = if1.ready;
      @(negedge clk);
    end
  endtask

  function automatic logic [127:0] pack(input int which, input int n);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < n; i++) begin
      case (which)
        0: v[i] = txl4[i];
        1: v[i] = rdl4[i];
        2: v[i] = bsl4[i];
        3: v[i] = txl1[i];
        default: v[i] = rdl1[i];
      endcase
    end
    return v;
  endfunction

  function automatic logic [127:0] mask(input int n);
    return (128'(1) << n) - 128'(1);
  endfunction

  // Expected line levels for one frame starting at index 0; ones beyond it.
  function automatic logic [127:0] frame_vec(input logic [7:0] b, input int cpb);
    logic [127:0] v;
    int k;
    v = '1;
    for (int i = 0; i < 10*cpb; i++) begin
      k = i / cpb;
      if (k == 0)      v[i] = 1'b0;
      else if (k == 9) v[i] = 1'b1;
      else             v[i] = b[k-1];
    end
    return v;
  endfunction

  task automatic test_reset();
    logic [127:0] obs;
    rst = 1'b1;
    if4.valid = 1'b0; if4.d = 8'h00;
    if1.valid = 1'b0; if1.d = 8'h00;
    @(negedge clk);
    n_checks++;
    if (tx4 !== 1'b1) $display("FAIL reset_txd: got %b expected 1", tx4); else n_pass++;
    n_checks++;
    if (if4.ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", if4.ready); else n_pass++;
    n_checks++;
    if (busy4 !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy4); else n_pass++;
    #5 rst = 1'b0;
    @(negedge clk);
    capture(0, 8);
    obs = pack(0, 8);
    n_checks++;
    if (obs !== mask(8)) $display("FAIL reset_idle_txd: got %h expected %h", obs, mask(8)); else n_pass++;
    obs = pack(1, 8);
    n_checks++;
    if (obs !== mask(8)) $display("FAIL reset_idle_ready: got %h expected %h", obs, mask(8)); else n_pass++;
    obs = pack(2, 8);
    n_checks++;
    if (obs !== '0) $display("FAIL reset_idle_busy: got %h expected 0", obs); else n_pass++;
  endtask

  task automatic test_single_byte();
    logic [127:0] obs, exp;
    if4.d = 8'b1001_1001; if4.valid = 1'b1;
    @(negedge clk);
    if4.valid = 1'b0;
    capture(0, 41);
    obs = pack(0, 41);
    exp = frame_vec(8'h99, 4) & mask(41);
    n_checks++;
    if (obs !== exp) $display("FAIL single_txd: got %h expected %h", obs, exp); else n_pass++;
    obs = pack(1, 41);
    exp = 128'(1) << 40;
    n_checks++;
    if (obs !== exp) $display("FAIL single_ready: got %h expected %h", obs, exp); else n_pass++;
    obs = pack(2, 41);
    exp = mask(40);
    n_checks++;
    if (obs !== exp) $display("FAIL single_busy: got %h expected %h", obs, exp); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [127:0] obs, exp, f1, f2;
    if4.d = 8'h01; if4.valid = 1'b1;
    @(negedge clk);
    if4.d = 8'h02;
    capture(0, 42);
    if4.valid = 1'b0;
    capture(42, 40);
    f1 = frame_vec(8'h01, 4);
    f2 = frame_vec(8'h02, 4);
    exp = mask(82);
    for (int i = 0; i < 40; i++) begin
      exp[i]    = f1[i];
      exp[41+i] = f2[i];
    end
    obs = pack(0, 82);
    n_checks++;
    if (obs !== exp) $display("FAIL b2b_txd: got %h expected %h", obs, exp); else n_pass++;
    obs = pack(1, 82);
    exp = (128'(1) << 40) | (128'(1) << 81);
    n_checks++;
    if (obs !== exp) $display("FAIL b2b_ready: got %h expected %h", obs, exp); else n_pass++;
  endtask

  task automatic test_ignore_busy();
    logic [127:0] obs, exp;
    if4.d = 8'h55; if4.valid = 1'b1;
    @(negedge clk);
    if4.valid = 1'b0;
    capture(0, 11);
    if4.d = 8'hFF; if4.valid = 1'b1;
    capture(11, 1);
    if4.valid = 1'b0;
    capture(12, 74);
    obs = pack(0, 86);
    exp = frame_vec(8'h55, 4) & mask(86);
    n_checks++;
    if (obs !== exp) $display("FAIL ignore_busy_txd: got %h expected %h", obs, exp); else n_pass++;
    obs = pack(1, 86);
    exp = mask(86) & ~mask(40);
    n_checks++;
    if (obs !== exp) $display("FAIL ignore_busy_ready: got %h expected %h", obs, exp); else n_pass++;
  endtask

  task automatic test_valid_drop();
    logic [127:0] obs;
    if4.d = 8'h00; if4.valid = 1'b1;
    #5 if4.valid = 1'b0;
    @(negedge clk);
    capture(0, 6);
    obs = pack(0, 6);
    n_checks++;
    if (obs !== mask(6)) $display("FAIL valid_drop_txd: got %h expected %h", obs, mask(6)); else n_pass++;
    obs = pack(1, 6);
    n_checks++;
    if (obs !== mask(6)) $display("FAIL valid_drop_ready: got %h expected %h", obs, mask(6)); else n_pass++;
  endtask

  task automatic test_reset_with_valid();
    logic [127:0] obs;
    rst = 1'b1; if4.d = 8'h00; if4.valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; if4.valid = 1'b0;
    capture(0, 6);
    obs = pack(0, 6);
    n_checks++;
    if (obs !== mask(6)) $display("FAIL rst_valid_txd: got %h expected %h", obs, mask(6)); else n_pass++;
    obs = pack(1, 6);
    n_checks++;
    if (obs !== mask(6)) $display("FAIL rst_valid_ready: got %h expected %h", obs, mask(6)); else n_pass++;
  endtask

  task automatic test_async_reset_mid_frame();
    logic [127:0] obs, exp;
    if4.d = 8'h00; if4.valid = 1'b1;
    @(negedge clk);
    if4.valid = 1'b0;
    capture(0, 17);
    n_checks++;
    if (tx4 !== 1'b0 || if4.ready !== 1'b0)
      $display("FAIL mid_frame_active: got txd=%b ready=%b expected txd=0 ready=0", tx4, if4.ready);
    else n_pass++;
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (tx4 !== 1'b1) $display("FAIL async_rst_txd: got %b expected 1", tx4); else n_pass++;
    n_checks++;
    if (if4.ready !== 1'b1) $display("FAIL async_rst_ready: got %b expected 1", if4.ready); else n_pass++;
    n_checks++;
    if (busy4 !== 1'b0) $display("FAIL async_rst_busy: got %b expected 0", busy4); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    if4.d = 8'hA5; if4.valid = 1'b1;
    @(negedge clk);
    if4.valid = 1'b0;
    capture(0, 41);
    obs = pack(0, 41);
    exp = frame_vec(8'hA5, 4) & mask(41);
    n_checks++;
    if (obs !== exp) $display("FAIL after_rst_txd: got %h expected %h", obs, exp); else n_pass++;
    obs = pack(1, 41);
    exp = 128'(1) << 40;
    n_checks++;
    if (obs !== exp) $display("FAIL after_rst_ready: got %h expected %h", obs, exp); else n_pass++;
  endtask

  task automatic test_cpb1();
    logic [127:0] obs;
    if1.d = 8'hC3; if1.valid = 1'b1;
    @(negedge clk);
    if1.valid = 1'b0;
    capture(0, 11);
    // line 0,1,1,0,0,0,0,1,1,1 then idle 1, index 0 in bit 0
    obs = pack(3, 11);
    n_checks++;
    if (obs !== 128'h786) $display("FAIL cpb1_txd: got %h expected 786", obs); else n_pass++;
    obs = pack(4, 11);
    n_checks++;
    if (obs !== 128'h400) $display("FAIL cpb1_ready: got %h expected 400", obs); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_ignore_busy();
    test_valid_drop();
    test_reset_with_valid();
    test_async_reset_mid_frame();
    test_cpb1();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
